// File: rtl/baud_pkg.sv
// ============================================================================
// Module      : baud_pkg
// Description : Shared mode encodings, state type and widths for baud_tick_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package baud_pkg;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int OSR_DEFAULT = 16;
    localparam int OSR_W       = $clog2(OSR_DEFAULT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/baud_tick_gen_if.sv
// ============================================================================
// Module      : baud_tick_gen_if
// Description : Control and tick bundle of baud_tick_gen; DivFrac exists only
//               when BAUD_FRAC_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface baud_tick_gen_if #(
    parameter int DIV_W  = 16,
    parameter int NB_W   = 4
`ifdef BAUD_FRAC_DIV_EN
    ,
    parameter int FRAC_W = 4
`endif
);

    logic             Enable;
    logic             Start;
    logic             Stop;
    logic             Mode;
    logic [DIV_W-1:0] Divisor;
    logic [NB_W-1:0]  NumBits;
`ifdef BAUD_FRAC_DIV_EN
    logic [FRAC_W-1:0] DivFrac;
`endif

    logic             SampleTick;
    logic             MidTick;
    logic             BitTick;
    logic [NB_W-1:0]  BitCount;
    logic             Done;
    logic             Busy;

    modport master (
`ifdef BAUD_FRAC_DIV_EN
        output DivFrac,
`endif
        output Enable, Start, Stop, Mode, Divisor, NumBits,
        input  SampleTick, MidTick, BitTick, BitCount, Done, Busy
    );

    modport slave (
`ifdef BAUD_FRAC_DIV_EN
        input  DivFrac,
`endif
        input  Enable, Start, Stop, Mode, Divisor, NumBits,
        output SampleTick, MidTick, BitTick, BitCount, Done, Busy
    );

endinterface

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module      : mod_counter
// Description : Modulo counter 0..FinalValue with clear and wrap strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Clear,
    input  logic [WIDTH-1:0] FinalValue,
    output logic [WIDTH-1:0] Count,
    output logic             Wrap
);

    logic [WIDTH-1:0] r_count;

    assign Wrap  = Enable & (r_count == FinalValue);
    assign Count = r_count;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (Clear) begin
            r_count <= '0;
        end else if (Wrap) begin
            r_count <= '0;
        end else if (Enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/baud_tick_gen.sv
// ============================================================================
// Module      : baud_tick_gen
// Description : Prescaled sample/mid/bit tick generator with frame Done pulse.
//               Optional fractional divisor enabled by macro BAUD_FRAC_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baud_tick_gen
    import baud_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int OSR    = 16,
    parameter int NB_W   = 4,
    parameter int FRAC_W = 4
) (
    input  logic           clk,
    input  logic           Reset,
    baud_tick_gen_if.slave bus
);

    localparam int c_SMP_W = $clog2(OSR);
`ifdef BAUD_FRAC_DIV_EN
    localparam int c_PRE_W = DIV_W + 1;
`else
    localparam int c_PRE_W = DIV_W;
`endif
    localparam logic [c_SMP_W-1:0] c_SMP_LAST = c_SMP_W'(OSR - 1);
    localparam logic [c_SMP_W-1:0] c_SMP_MID  = c_SMP_W'(OSR / 2 - 1);

    generate
        if ((OSR < 2) || ((OSR % 2) != 0)) begin : g_bad_osr
            $error("baud_tick_gen: OSR must be even and at least 2");
        end
        if (FRAC_W < 1) begin : g_bad_frac
            $error("baud_tick_gen: FRAC_W must be at least 1");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DIV_W-1:0]   r_div_l;
    logic               r_mode;
    logic [NB_W-1:0]    r_nb_last;

    logic               w_busy;
    logic               w_latch;
    logic               w_clear;
    logic               w_run_en;
    logic               w_pre_wrap;
    logic               w_sample;
    logic               w_bit;
    logic               w_done;
    logic [c_PRE_W-1:0] w_pre;
    logic [c_PRE_W-1:0] w_pre_last;
    logic [c_SMP_W-1:0] w_smp;
    logic [NB_W-1:0]    w_bitcnt;

    assign w_busy   = (r_state == RUN);
    assign w_run_en = w_busy & bus.Enable;
    // Stop outranks Start, so a coincident Start never re-latches or re-arms.
    assign w_latch  = bus.Start & ~bus.Stop;
    assign w_clear  = bus.Start | bus.Stop | ~w_busy;
    assign w_sample = w_pre_wrap & (w_pre == w_pre_last);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_div_l   <= '0;
            r_mode    <= MODE_PERIODIC;
            r_nb_last <= '0;
        end else if (w_latch) begin
            r_div_l   <= bus.Divisor;
            r_mode    <= bus.Mode;
            r_nb_last <= (bus.NumBits == '0) ? '0 : bus.NumBits - 1'b1;
        end
    end

`ifdef BAUD_FRAC_DIV_EN
    logic [FRAC_W-1:0] r_frac;
    logic [FRAC_W-1:0] r_acc;
    logic              r_ext;
    logic [FRAC_W:0]   w_acc_sum;

    assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_frac};

    // A carry stretches the following prescaler period by one clock.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_frac <= '0;
            r_acc  <= '0;
            r_ext  <= 1'b0;
        end else begin
            if (w_latch) begin
                r_frac <= bus.DivFrac;
            end
            if (bus.Start | bus.Stop) begin
                r_acc <= '0;
                r_ext <= 1'b0;
            end else if (w_sample) begin
                r_acc <= w_acc_sum[FRAC_W-1:0];
                r_ext <= w_acc_sum[FRAC_W];
            end
        end
    end

    assign w_pre_last = {1'b0, r_div_l} + c_PRE_W'(r_ext);
`else
    assign w_pre_last = r_div_l;
`endif

    mod_counter #(.WIDTH(c_PRE_W)) u_pre (
        .clk        (clk),
        .Reset      (Reset),
        .Enable     (w_run_en),
        .Clear      (w_clear),
        .FinalValue (w_pre_last),
        .Count      (w_pre),
        .Wrap       (w_pre_wrap)
    );

    mod_counter #(.WIDTH(c_SMP_W)) u_smp (
        .clk        (clk),
        .Reset      (Reset),
        .Enable     (w_sample),
        .Clear      (w_clear),
        .FinalValue (c_SMP_LAST),
        .Count      (w_smp),
        .Wrap       (w_bit)
    );

    mod_counter #(.WIDTH(NB_W)) u_bit (
        .clk        (clk),
        .Reset      (Reset),
        .Enable     (w_bit),
        .Clear      (w_clear),
        .FinalValue (r_nb_last),
        .Count      (w_bitcnt),
        .Wrap       (w_done)
    );

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_latch) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.Stop) begin
                    w_state_nxt = IDLE;
                end else if (bus.Start) begin
                    w_state_nxt = RUN;
                end else if (w_done && (r_mode == MODE_ONESHOT)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.SampleTick = w_sample;
    assign bus.MidTick    = w_sample & (w_smp == c_SMP_MID);
    assign bus.BitTick    = w_bit;
    assign bus.BitCount   = w_bitcnt;
    assign bus.Done       = w_done;
    assign bus.Busy       = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
// ============================================================================
// Module      : tb_baud_tick_gen
// Description : Directed scoreboard bench for baud_tick_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_baud_tick_gen;
    import baud_pkg::*;

    logic clk = 1'b0;
    logic Reset;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int bits_seen = 0;
    int nb_cur    = 1;
    int busy_end  = 0;
    int gap_lo    = 0;
    int gap_hi    = -1;

    int q_smp[$];
    int q_mid[$];
    int q_bit[$];
    int q_done[$];

    always #5 clk = ~clk;

`ifdef BAUD_FRAC_DIV_EN
    baud_tick_gen_if #(.DIV_W(16), .NB_W(4), .FRAC_W(4)) bus ();
`else
    baud_tick_gen_if #(.DIV_W(16), .NB_W(4)) bus ();
`endif

    baud_tick_gen #(.DIV_W(16), .OSR(16), .NB_W(4), .FRAC_W(4)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_tick(input string tag, input int kind, input logic obs);
        logic exp;
        exp = 1'b0;
        case (kind)
            0: if (q_smp.size() > 0 && q_smp[0] == cyc) begin exp = 1'b1; void'(q_smp.pop_front()); end
            1: if (q_mid.size() > 0 && q_mid[0] == cyc) begin exp = 1'b1; void'(q_mid.pop_front()); end
            2: if (q_bit.size() > 0 && q_bit[0] == cyc) begin exp = 1'b1; void'(q_bit.pop_front()); end
            default: if (q_done.size() > 0 && q_done[0] == cyc) begin exp = 1'b1; void'(q_done.pop_front()); end
        endcase
        chk(tag, {31'b0, obs}, {31'b0, exp});
        if (kind == 2 && exp) bits_seen++;
    endtask

    // Expected tick cycles from the nominal period, shifted by any Enable gap.
    task automatic push_run(input int d, input int nb, input int ntick,
                            input int glo, input int glen, input int last);
        int c;
        for (int n = 1; n <= ntick; n++) begin
            c = n * (d + 1);
            if (glen > 0 && c >= glo) c = c + glen;
            if (c > last) break;
            q_smp.push_back(c);
            if (((n - 1) % 16) == 7) q_mid.push_back(c);
            if (((n - 1) % 16) == 15) begin
                q_bit.push_back(c);
                if ((((n - 1) / 16) % nb) == nb - 1) q_done.push_back(c);
            end
        end
    endtask

    task automatic start_run(input int div, input logic mode, input int numbits);
        bus.Divisor = 16'(div);
        bus.Mode    = mode;
        bus.NumBits = 4'(numbits);
        bus.Start   = 1'b1;
        cyc         = 0;
        bits_seen   = 0;
        nb_cur      = (numbits == 0) ? 1 : numbits;
    endtask

    task automatic observe(input int n);
        logic exp_busy;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            bus.Start  = 1'b0;
            bus.Stop   = 1'b0;
            bus.Enable = (cyc >= gap_lo && cyc <= gap_hi) ? 1'b0 : 1'b1;
            @(negedge clk);
            exp_busy = (cyc >= 1 && cyc <= busy_end);
            chk("Busy", {31'b0, bus.Busy}, {31'b0, exp_busy});
            if (exp_busy) chk("BitCount", {28'b0, bus.BitCount}, bits_seen % nb_cur);
            chk_tick("SampleTick", 0, bus.SampleTick);
            chk_tick("MidTick", 1, bus.MidTick);
            chk_tick("BitTick", 2, bus.BitTick);
            chk_tick("Done", 3, bus.Done);
        end
    endtask

    task automatic chk_empty();
        chk("pending_sample", q_smp.size(), 0);
        chk("pending_mid", q_mid.size(), 0);
        chk("pending_bit", q_bit.size(), 0);
        chk("pending_done", q_done.size(), 0);
        q_smp.delete();
        q_mid.delete();
        q_bit.delete();
        q_done.delete();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_Busy"}, {31'b0, bus.Busy}, 0);
        chk({tag, "_SampleTick"}, {31'b0, bus.SampleTick}, 0);
        chk({tag, "_MidTick"}, {31'b0, bus.MidTick}, 0);
        chk({tag, "_BitTick"}, {31'b0, bus.BitTick}, 0);
        chk({tag, "_Done"}, {31'b0, bus.Done}, 0);
        chk({tag, "_BitCount"}, {28'b0, bus.BitCount}, 0);
    endtask

    initial begin
        Reset       = 1'b1;
        bus.Enable  = 1'b1;
        bus.Start   = 1'b0;
        bus.Stop    = 1'b0;
        bus.Mode    = MODE_PERIODIC;
        bus.Divisor = '0;
        bus.NumBits = '0;
`ifdef BAUD_FRAC_DIV_EN
        bus.DivFrac = '0;
`endif
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        Reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        // One-shot frame: Divisor 3, 10 bits, Done at 640, idle from 641.
        start_run(3, MODE_ONESHOT, 10);
        push_run(3, 10, 160, 0, 0, 1000000);
        busy_end = 640;
        observe(645);
        chk_empty();

        // Periodic, every cycle a sample; then Stop and Start together at 100.
        start_run(0, MODE_PERIODIC, 2);
        push_run(0, 2, 100, 0, 0, 100);
        busy_end = 100;
        observe(100);
        bus.Stop  = 1'b1;
        bus.Start = 1'b1;
        observe(10);
        chk_empty();

        // Enable low for cycles 10..14 delays every later tick by 5.
        start_run(3, MODE_ONESHOT, 1);
        gap_lo = 10;
        gap_hi = 14;
        push_run(3, 1, 16, 10, 5, 1000000);
        busy_end = 69;
        observe(75);
        gap_lo = 0;
        gap_hi = -1;
        chk_empty();

        // Asynchronous reset at cycle 100, then restart with Divisor 7, NumBits 0.
        start_run(3, MODE_PERIODIC, 10);
        push_run(3, 10, 1000, 0, 0, 99);
        busy_end = 1000000;
        observe(99);
        @(posedge clk);
        cyc++;
        #1;
        Reset = 1'b1;
        #1;
        chk_idle_outputs("async_reset");
        chk_empty();
        @(negedge clk);
        Reset = 1'b0;
        start_run(7, MODE_ONESHOT, 0);
        push_run(7, 1, 16, 0, 0, 1000000);
        busy_end = 128;
        observe(135);
        chk_empty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
